// File: rtl/customer_gen.sv
// customer_gen: ticket dispenser issuing numbered customers with LFSR service times
module customer_gen #(
   parameter logic [7:0] SEED = 8'hA5,
   parameter int         GAP  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       full,
   output logic       out_valid,
   output logic [3:0] out_num,
   output logic [3:0] out_time,
   output logic [1:0] pend_cnt,
   output logic       drop,
   output logic [7:0] issued_cnt
);
   localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [3:0] GAP_M1  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
   state_t state, state_n;
   logic req_d, rise, start;
   logic [7:0] lfsr;
   logic [3:0] gap_cnt;
   logic [2:0] t;
   assign rise = req & ~req_d;
   assign start = (state == S_IDLE) & (pend_cnt != 2'd0);
   assign out_valid = (state == S_ISSUE) & ~full & ~rst;
   assign drop = rise & (pend_cnt == 2'd3) & ~out_valid & ~rst;
   assign t = lfsr[2:0];
   always_comb begin
      state_n = state;
      state_n = start ? S_ISSUE :
                out_valid ? ((GAP == 0) ? S_IDLE : S_GAP) :
                (state == S_GAP && gap_cnt == 4'd0) ? S_IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         req_d      <= 1'b1;
         lfsr       <= SEED_NZ;
         pend_cnt   <= 2'd0;
         issued_cnt <= 8'd0;
         out_num    <= 4'd1;
         out_time   <= 4'd0;
         gap_cnt    <= 4'd0;
      end else begin
         state <= state_n;
         req_d <= req;
         lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (rise && !out_valid && pend_cnt != 2'd3)
            pend_cnt <= pend_cnt + 2'd1;
         else if (!rise && out_valid)
            pend_cnt <= pend_cnt - 2'd1;
         if (start)
            out_time <= (t != 3'd0) ? {1'b0, t} : 4'd1;
         if (out_valid) begin
            out_num    <= (out_num == 4'd15) ? 4'd1 : out_num + 4'd1;
            issued_cnt <= issued_cnt + 8'd1;
            gap_cnt    <= GAP_M1;
         end else if (state == S_GAP)
            gap_cnt <= gap_cnt - 4'd1;
      end
   end
endmodule

// File: tb/tb_customer_gen.sv
// tb_customer_gen: per-cycle vector tables plus a ticket scoreboard for customer_gen
module tb_customer_gen;
   localparam logic [7:0] SEED = 8'hA5;
   localparam int         GAP  = 2;
   localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;
   logic clk = 1'b0, rst = 1'b1, req = 1'b1, full = 1'b0;
   logic out_valid, drop;
   logic [3:0] out_num, out_time;
   logic [1:0] pend_cnt;
   logic [7:0] issued_cnt;
   customer_gen #(.SEED(SEED), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .req(req), .full(full),
      .out_valid(out_valid), .out_num(out_num), .out_time(out_time),
      .pend_cnt(pend_cnt), .drop(drop), .issued_cnt(issued_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {logic rst, req, full, valid, drop; logic [1:0] pend; int lat;} vec_t;
   typedef struct {logic [3:0] num; int lat;} tkt_t;
   vec_t tab[128];
   logic [7:0] lhist[128];
   tkt_t sb[$];
   int n;
   logic [7:0] mlfsr = 8'h00;
   logic [3:0] next_num = 4'd1;
   string scen = "";
   int total = 0, passed = 0;
   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s/%s cycle %0d: got %0d, expected %0d", scen, name, c, act, exp);
   endtask
   function automatic logic [7:0] step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction
   function automatic logic [3:0] shape(input logic [7:0] l);
      return (l[2:0] != 3'd0) ? {1'b0, l[2:0]} : 4'd1;
   endfunction
   // Every scenario opens with two reset cycles; the rest defaults to idle inputs.
   task automatic clr(input int len);
      n = len;
      for (int i = 0; i < len; i++) tab[i] = '{i < 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, -1};
   endtask
   task automatic run_tab();
      tkt_t t;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         rst = tab[c].rst;
         req = tab[c].req;
         full = tab[c].full;
         if (rst) begin
            sb.delete();
            next_num = 4'd1;
         end
         if (tab[c].lat >= 0) begin
            sb.push_back('{next_num, tab[c].lat});
            next_num = (next_num == 4'd15) ? 4'd1 : next_num + 4'd1;
         end
         #1;
         lhist[c] = mlfsr;
         chk("out_valid", c, out_valid, tab[c].valid);
         chk("drop", c, drop, tab[c].drop);
         if (c >= 2) chk("pend_cnt", c, pend_cnt, tab[c].pend);
         if (c == 2) begin
            chk("rst_out_num", c, out_num, 4'd1);
            chk("rst_out_time", c, out_time, 4'd0);
            chk("rst_issued_cnt", c, issued_cnt, 8'd0);
         end
         if (out_valid) begin
            chk("ticket_expected", c, sb.size() > 0, 1);
            if (sb.size() > 0) begin
               t = sb.pop_front();
               chk("out_num", c, out_num, t.num);
               chk("out_time", c, out_time, shape(lhist[t.lat]));
            end
         end
         mlfsr = rst ? SEED_NZ : step(mlfsr);
      end
      chk("tickets_outstanding", n, sb.size(), 0);
   endtask
   initial begin
      scen = "single";
      clr(16);
      for (int c = 0; c < 8; c++) tab[c].req = 1'b1;
      for (int c = 10; c < 16; c++) tab[c].req = 1'b1;
      tab[10].lat = 11;
      tab[11].pend = 2'd1;
      tab[12].pend = 2'd1;
      tab[12].valid = 1'b1;
      run_tab();
      chk("issued_cnt", n, issued_cnt, 8'd1);
      chk("num_after", n, out_num, 4'd2);
      chk("time_held", n, out_time, shape(lhist[11]));
      scen = "burst";
      clr(37);
      for (int c = 10; c <= 22; c += 2) tab[c].req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tab[10 + 2 * k].lat = 11 + 4 * k;
         tab[12 + 4 * k].valid = 1'b1;
      end
      tab[22].drop = 1'b1;
      for (int c = 11; c <= 32; c++)
         tab[c].pend = (c < 15) ? 2'd1 : (c < 19) ? 2'd2 : (c < 25) ? 2'd3 : (c < 29) ? 2'd2 : 2'd1;
      run_tab();
      chk("issued_cnt", n, issued_cnt, 8'd6);
      scen = "backpressure";
      clr(20);
      for (int c = 10; c < 20; c++) tab[c].req = 1'b1;
      for (int c = 12; c < 16; c++) tab[c].full = 1'b1;
      for (int c = 11; c < 17; c++) tab[c].pend = 2'd1;
      tab[10].lat = 11;
      tab[16].valid = 1'b1;
      run_tab();
      chk("issued_cnt", n, issued_cnt, 8'd1);
      scen = "mid_reset";
      clr(22);
      for (int c = 10; c < 14; c++) tab[c].req = 1'b1;
      for (int c = 16; c < 22; c++) tab[c].req = 1'b1;
      tab[10].lat = 11;
      tab[11].pend = 2'd1;
      tab[12].pend = 2'd1;
      tab[12].rst = 1'b1;
      tab[16].lat = 17;
      tab[17].pend = 2'd1;
      tab[18].pend = 2'd1;
      tab[18].valid = 1'b1;
      run_tab();
      chk("issued_cnt", n, issued_cnt, 8'd1);
      scen = "wrap";
      clr(78);
      for (int k = 0; k < 16; k++) begin
         tab[10 + 4 * k].req = 1'b1;
         tab[10 + 4 * k].lat = 11 + 4 * k;
         tab[11 + 4 * k].pend = 2'd1;
         tab[12 + 4 * k].pend = 2'd1;
         tab[12 + 4 * k].valid = 1'b1;
      end
      run_tab();
      chk("issued_cnt", n, issued_cnt, 8'd16);
      chk("num_after", n, out_num, 4'd2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
